// File: rtl/if_fetch_unit.sv
// if_fetch_unit: MIPS instruction fetch with IF/ID register, one outstanding request and a one-entry skid buffer
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        Stall,
  input  logic [1:0]  PCSrc2,
  input  logic        Branch,
  input  logic        Zero,
  input  logic [31:0] JumpRegAddr,
  output logic [31:0] Instruction,
  output logic [31:0] InstrPC,
  output logic [31:0] PCPlus4,
  output logic        InstrValid,
  output logic [5:0]  OpCode,
  output logic [5:0]  Funct
);
  typedef enum logic [1:0] {S_FETCH, S_WAIT, S_HOLD} state_t;
  state_t      state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d, req_pc_q, req_pc_d;
  logic [31:0] skid_data_q, skid_data_d, skid_pc_q, skid_pc_d;
  logic [31:0] instr_q, instr_d, ipc_q, ipc_d;
  logic        squash_q, squash_d, valid_q, valid_d;
  logic        consume, taken, accept, loadable;
  logic [31:0] pc_plus4, target;
  assign pc_plus4       = ipc_q + 32'd4;
  assign consume        = valid_q & ~Stall;
  assign taken          = consume & ((PCSrc2 != 2'b00) | (Branch & Zero));
  assign loadable       = ~valid_q | consume;
  assign imem_req_valid = rst_n & (state_q == S_FETCH);
  assign imem_req_addr  = fetch_pc_q;
  assign accept         = imem_req_valid & imem_req_ready;
  assign target = PCSrc2[1] ? JumpRegAddr :
                  PCSrc2[0] ? {pc_plus4[31:28], instr_q[25:0], 2'b00} :
                  pc_plus4 + {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
  assign Instruction = instr_q;
  assign InstrPC     = ipc_q;
  assign PCPlus4     = pc_plus4;
  assign InstrValid  = valid_q;
  assign OpCode      = instr_q[31:26];
  assign Funct       = instr_q[5:0];
  always_comb begin
    state_d     = state_q;
    squash_d    = squash_q;
    fetch_pc_d  = taken ? target : accept ? fetch_pc_q + 32'd4 : fetch_pc_q;
    req_pc_d    = accept ? fetch_pc_q : req_pc_q;
    skid_data_d = skid_data_q;
    skid_pc_d   = skid_pc_q;
    instr_d     = instr_q;
    ipc_d       = ipc_q;
    valid_d     = valid_q & ~consume;
    case (state_q)
      S_FETCH: if (accept) begin
        state_d  = S_WAIT;
        squash_d = taken;
      end
      S_WAIT: if (imem_resp_valid) begin
        // a response arriving alongside a redirect is wrong-path and simply dropped
        state_d  = S_FETCH;
        squash_d = 1'b0;
        if (!squash_q && !taken) begin
          if (loadable) begin
            instr_d = imem_resp_data;
            ipc_d   = req_pc_q;
            valid_d = 1'b1;
          end else begin
            skid_data_d = imem_resp_data;
            skid_pc_d   = req_pc_q;
            state_d     = S_HOLD;
          end
        end
      end else if (taken) begin
        squash_d = 1'b1;
      end
      S_HOLD: if (taken) begin
        state_d = S_FETCH;
      end else if (loadable) begin
        instr_d = skid_data_q;
        ipc_d   = skid_pc_q;
        valid_d = 1'b1;
        state_d = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_FETCH;
      squash_q    <= 1'b0;
      fetch_pc_q  <= RESET_PC;
      req_pc_q    <= '0;
      skid_data_q <= '0;
      skid_pc_q   <= '0;
      instr_q     <= '0;
      ipc_q       <= '0;
      valid_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      squash_q    <= squash_d;
      fetch_pc_q  <= fetch_pc_d;
      req_pc_q    <= req_pc_d;
      skid_data_q <= skid_data_d;
      skid_pc_q   <= skid_pc_d;
      instr_q     <= instr_d;
      ipc_q       <= ipc_d;
      valid_q     <= valid_d;
    end
  end
endmodule
